// File: rtl/grf_arb_pkg.sv
// rtl/grf_arb_pkg.sv - shared types and widths for the GRF write-port arbiter
package grf_arb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  dst_reg;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    typedef enum logic {
        NORMAL,
        FORCE
    } arb_state_e;

endpackage

// File: rtl/grf_wb_fifo.sv
// rtl/grf_wb_fifo.sv - in-order queue of pending aux write-back entries
module grf_wb_fifo
    import grf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [ENTRY_W-1:0]       entry_i,
    output logic [ENTRY_W-1:0]       head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [DEPTH-1:0]         valid_o,
    output logic [DEPTH*REG_W-1:0]   regs_o
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    // Per-slot valid bits replace an occupancy counter; slots stay contiguous.
    always_comb begin
        valid_d = valid_q;
        if (pop_i) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wb_entry_t'(entry_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = &valid_q;
    assign empty_o = ~|valid_q;
    assign valid_o = valid_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_regs
        assign regs_o[i*REG_W +: REG_W] = mem_q[i].dst_reg;
    end

endmodule

// File: rtl/mod_grf_wb_arb.sv
// rtl/mod_grf_wb_arb.sv - GRF write-port arbiter: W stage first, aux results drained on idle cycles
module mod_grf_wb_arb
    import grf_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [4:0]        pipe_reg,
    input  logic [31:0]       pipe_data,
    input  logic [31:0]       pipe_pc,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [4:0]        aux_reg,
    input  logic [31:0]       aux_data,
    input  logic [31:0]       aux_pc,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              stall_req,
    output logic              grf_write,
    output logic [4:0]        grf_reg_in,
    output logic [31:0]       grf_data_in,
    output logic [31:0]       pc_now
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [DEPTH-1:0]       slot_valid;
    logic [DEPTH*REG_W-1:0] slot_regs;
    wb_entry_t              aux_entry;
    wb_entry_t              head;
    logic [ENTRY_W-1:0]     head_flat;
    arb_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    assign aux_ready = !fifo_full && !reset;
    // Writes to $0 are acknowledged but never occupy a slot.
    assign push      = aux_valid && aux_ready && (aux_reg != '0);
    assign pop       = !reset && !pipe_we && !fifo_empty;
    assign aux_entry = '{dst_reg: aux_reg, data: aux_data, pc: aux_pc};
    assign head      = wb_entry_t'(head_flat);

    grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .entry_i (aux_entry),
        .head_o  (head_flat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .valid_o (slot_valid),
        .regs_o  (slot_regs)
    );

    always_comb begin
        grf_write   = 1'b0;
        grf_reg_in  = '0;
        grf_data_in = '0;
        pc_now      = '0;
        if (!reset) begin
            if (pipe_we) begin
                grf_write   = 1'b1;
                grf_reg_in  = pipe_reg;
                grf_data_in = pipe_data;
                pc_now      = pipe_pc;
            end else if (!fifo_empty) begin
                grf_write   = 1'b1;
                grf_reg_in  = head.dst_reg;
                grf_data_in = head.data;
                pc_now      = head.pc;
            end
        end
    end

    always_comb begin
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset && slot_valid[i]) begin
                if (rs != '0 && slot_regs[i*REG_W +: REG_W] == rs) begin
                    rs_busy = 1'b1;
                end
                if (rt != '0 && slot_regs[i*REG_W +: REG_W] == rt) begin
                    rt_busy = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            NORMAL: begin
                if (fifo_empty || pop) begin
                    cnt_d = '0;
                end else if (pipe_we) begin
                    if (int'(cnt_q) + 1 >= STARVE_LIMIT) begin
                        state_d = FORCE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FORCE: begin
                // A W write during FORCE is a pipeline protocol error; hold the bubble request.
                cnt_d = '0;
                if (pop || fifo_empty) begin
                    state_d = NORMAL;
                end
            end
            default: begin
                state_d = NORMAL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_req = (state_q == FORCE) && !reset;

endmodule
